// File: rtl/branch_resolve_ctrl_pkg.sv
// branch_resolve_ctrl_pkg: shared widths, comparator op encodings and resolver state encoding
package branch_resolve_ctrl_pkg;
  localparam int XLEN = 32;
  localparam int BRANCH_OP_WIDTH = 3;
  typedef logic [BRANCH_OP_WIDTH-1:0] br_op_t;
  localparam br_op_t ALU_OP_BEQ  = 3'b000;
  localparam br_op_t ALU_OP_BNE  = 3'b001;
  localparam br_op_t ALU_OP_BLT  = 3'b100;
  localparam br_op_t ALU_OP_BGE  = 3'b101;
  localparam br_op_t ALU_OP_BLTU = 3'b110;
  localparam br_op_t ALU_OP_BGEU = 3'b111;
  localparam logic [1:0] BR_STATE_IDLE  = 2'd0;
  localparam logic [1:0] BR_STATE_EVAL  = 2'd1;
  localparam logic [1:0] BR_STATE_FLUSH = 2'd2;
endpackage

// File: rtl/branch_resolve_ctrl_branch_comp.sv
// branch_comp: shared conditional-branch comparator; unknown ops resolve not-taken
module branch_comp
  import branch_resolve_ctrl_pkg::*;
#(
  parameter int W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  br_op_t       op,
  output logic         cmp_out
);
  always_comb
    cmp_out = op == ALU_OP_BEQ  ? a == b :
              op == ALU_OP_BNE  ? a != b :
              op == ALU_OP_BLT  ? $signed(a) <  $signed(b) :
              op == ALU_OP_BGE  ? $signed(a) >= $signed(b) :
              op == ALU_OP_BLTU ? a <  b :
              op == ALU_OP_BGEU ? a >= b : 1'b0;
endmodule

// File: rtl/branch_resolve_ctrl.sv
// branch_resolve_ctrl: resolves one branch/jump per handshake, redirects fetch and
// holds a counted flush on mispredict
module branch_resolve_ctrl #(
  parameter int XLEN = branch_resolve_ctrl_pkg::XLEN,
  parameter int FLUSH_CYCLES = 2,
  parameter int CNT_W = 4
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          req_valid,
  output logic                                          req_ready,
  input  logic [XLEN-1:0]                               req_pc,
  input  logic [XLEN-1:0]                               req_rs1,
  input  logic [XLEN-1:0]                               req_rs2,
  input  logic [XLEN-1:0]                               req_imm,
  input  logic [branch_resolve_ctrl_pkg::BRANCH_OP_WIDTH-1:0] req_br_op,
  input  logic                                          req_is_jal,
  input  logic                                          req_is_jalr,
  input  logic                                          req_pred_taken,
  input  logic [XLEN-1:0]                               req_pred_target,
  input  logic                                          kill,
  output logic                                          resp_valid,
  output logic                                          resp_taken,
  output logic                                          resp_mispredict,
  output logic                                          resp_misalign,
  output logic [XLEN-1:0]                               link_data,
  output logic                                          redirect_valid,
  output logic [XLEN-1:0]                               redirect_pc,
  output logic                                          flush
);
  import branch_resolve_ctrl_pkg::*;
  logic [1:0] state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] pc_q, pc_d, rs1_q, rs1_d, rs2_q, rs2_d, imm_q, imm_d, ptgt_q, ptgt_d;
  br_op_t op_q, op_d;
  logic jal_q, jal_d, jalr_q, jalr_d, pt_q, pt_d;
  logic accept, eval, live, cmp_out, taken, mispred, misalign, redir;
  logic [XLEN-1:0] target, pc4, next_pc;
  branch_comp #(.W(XLEN)) u_comp (.a(rs1_q), .b(rs2_q), .op(op_q), .cmp_out(cmp_out));
  always_comb begin
    req_ready = state_q == BR_STATE_IDLE && !kill;
    accept    = req_valid && req_ready;
    eval      = state_q == BR_STATE_EVAL;
    live      = eval && !kill;
    taken     = jal_q || jalr_q || cmp_out;
    target    = jalr_q ? (rs1_q + imm_q) & ~XLEN'(1) : pc_q + imm_q;
    pc4       = pc_q + XLEN'(4);
    next_pc   = taken ? target : pc4;
    mispred   = taken != pt_q || (taken && pt_q && target != ptgt_q);
    misalign  = taken && target[1];
    redir     = mispred && !misalign;
    resp_valid      = live;
    resp_taken      = live && taken;
    resp_mispredict = live && mispred;
    resp_misalign   = live && misalign;
    link_data       = live ? pc4 : '0;
    redirect_valid  = live && redir;
    redirect_pc     = redirect_valid ? next_pc : '0;
    flush           = state_q == BR_STATE_FLUSH;
    pc_d   = accept ? req_pc : pc_q;
    rs1_d  = accept ? req_rs1 : rs1_q;
    rs2_d  = accept ? req_rs2 : rs2_q;
    imm_d  = accept ? req_imm : imm_q;
    ptgt_d = accept ? req_pred_target : ptgt_q;
    op_d   = accept ? req_br_op : op_q;
    jal_d  = accept ? req_is_jal : jal_q;
    jalr_d = accept ? req_is_jalr : jalr_q;
    pt_d   = accept ? req_pred_taken : pt_q;
    // counter runs FLUSH_CYCLES..1 while in FLUSH, so flush spans exactly FLUSH_CYCLES cycles
    state_d = kill   ? BR_STATE_IDLE :
              accept ? BR_STATE_EVAL :
              eval   ? (redir ? BR_STATE_FLUSH : BR_STATE_IDLE) :
              flush  ? (cnt_q == CNT_W'(1) ? BR_STATE_IDLE : BR_STATE_FLUSH) : state_q;
    cnt_d   = kill           ? '0 :
              eval && redir  ? CNT_W'(FLUSH_CYCLES) :
              flush          ? cnt_q - CNT_W'(1) : cnt_q;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= BR_STATE_IDLE;
      cnt_q   <= '0;
      pc_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      imm_q   <= '0;
      ptgt_q  <= '0;
      op_q    <= '0;
      jal_q   <= 1'b0;
      jalr_q  <= 1'b0;
      pt_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pc_q    <= pc_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      imm_q   <= imm_d;
      ptgt_q  <= ptgt_d;
      op_q    <= op_d;
      jal_q   <= jal_d;
      jalr_q  <= jalr_d;
      pt_q    <= pt_d;
    end
endmodule

// File: tb/tb_branch_resolve_ctrl.sv
// tb_branch_resolve_ctrl: directed plan cases plus randomized transactions against a behavioural model
module tb_branch_resolve_ctrl;
  import branch_resolve_ctrl_pkg::*;
  localparam int FC = 2;
  logic clk = 0, rst_n = 0;
  logic req_valid = 0, req_is_jal = 0, req_is_jalr = 0, req_pred_taken = 0, kill = 0;
  logic [31:0] req_pc = 0, req_rs1 = 0, req_rs2 = 0, req_imm = 0, req_pred_target = 0;
  br_op_t req_br_op = '0;
  logic req_ready, resp_valid, resp_taken, resp_mispredict, resp_misalign, redirect_valid, flush;
  logic [31:0] link_data, redirect_pc;
  int vecs = 0, errs = 0;
  branch_resolve_ctrl #(.XLEN(32), .FLUSH_CYCLES(FC), .CNT_W(4)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_ready(req_ready),
    .req_pc(req_pc), .req_rs1(req_rs1), .req_rs2(req_rs2), .req_imm(req_imm),
    .req_br_op(req_br_op), .req_is_jal(req_is_jal), .req_is_jalr(req_is_jalr),
    .req_pred_taken(req_pred_taken), .req_pred_target(req_pred_target), .kill(kill),
    .resp_valid(resp_valid), .resp_taken(resp_taken), .resp_mispredict(resp_mispredict),
    .resp_misalign(resp_misalign), .link_data(link_data), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .flush(flush));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecs++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  function automatic logic [31:0] tgt_of(input logic [31:0] pc, rs1, imm, input logic jalr);
    return jalr ? (rs1 + imm) & 32'hFFFF_FFFE : pc + imm;
  endfunction
  function automatic void model(input logic [31:0] pc, rs1, rs2, imm, input br_op_t op,
                                input logic jal, jalr, pt, input logic [31:0] ptgt,
                                output logic t, m, a, output logic [31:0] npc);
    logic c;
    logic [31:0] tg;
    case (op)
      3'b000: c = rs1 == rs2;
      3'b001: c = rs1 != rs2;
      3'b100: c = $signed(rs1) < $signed(rs2);
      3'b101: c = $signed(rs1) >= $signed(rs2);
      3'b110: c = rs1 < rs2;
      3'b111: c = rs1 >= rs2;
      default: c = 1'b0;
    endcase
    t = jal | jalr | c;
    tg = tgt_of(pc, rs1, imm, jalr);
    npc = t ? tg : pc + 32'd4;
    m = (t != pt) || (t && pt && tg != ptgt);
    a = t && tg[1];
  endfunction
  task automatic drive(input logic [31:0] pc, rs1, rs2, imm, input br_op_t op,
                       input logic jal, jalr, pt, input logic [31:0] ptgt);
    req_pc = pc; req_rs1 = rs1; req_rs2 = rs2; req_imm = imm; req_br_op = op;
    req_is_jal = jal; req_is_jalr = jalr; req_pred_taken = pt; req_pred_target = ptgt;
    req_valid = 1;
  endtask
  // entered and left just after a falling edge with the DUT idle
  task automatic xact(input logic [31:0] pc, rs1, rs2, imm, input br_op_t op,
                      input logic jal, jalr, pt, input logic [31:0] ptgt, input bit ke, kf);
    logic t, m, a, rd;
    logic [31:0] npc;
    model(pc, rs1, rs2, imm, op, jal, jalr, pt, ptgt, t, m, a, npc);
    rd = m && !a && !ke;
    check("ready_idle", 32'(req_ready), 1);
    drive(pc, rs1, rs2, imm, op, jal, jalr, pt, ptgt);
    @(negedge clk);
    req_valid = 0;
    kill = ke;
    #1;
    check("ready_eval", 32'(req_ready), 0);
    check("resp_valid", 32'(resp_valid), 32'(!ke));
    check("redirect_valid", 32'(redirect_valid), 32'(rd));
    if (!ke) begin
      check("resp_taken", 32'(resp_taken), 32'(t));
      check("resp_mispredict", 32'(resp_mispredict), 32'(m));
      check("resp_misalign", 32'(resp_misalign), 32'(a));
      check("link_data", link_data, pc + 32'd4);
      if (rd) check("redirect_pc", redirect_pc, npc);
    end
    @(negedge clk);
    kill = 0;
    #1;
    if (rd)
      for (int i = 0; i < FC; i++) begin
        check("flush_on", 32'(flush), 1);
        check("ready_flush", 32'(req_ready), 0);
        check("resp_in_flush", 32'(resp_valid), 0);
        if (kf) begin
          kill = 1;
          @(negedge clk);
          kill = 0;
          #1;
          break;
        end
        @(negedge clk);
        #1;
      end
    check("flush_off", 32'(flush), 0);
    check("ready_back", 32'(req_ready), 1);
  endtask
  initial begin
    logic [31:0] pc, rs1, rs2, imm, ptgt;
    br_op_t op;
    logic jal, jalr, pt;
    int r;
    #2;
    check("rst_ready", 32'(req_ready), 1);
    check("rst_outs", {resp_valid, resp_taken, resp_mispredict, resp_misalign, redirect_valid, flush}, 0);
    check("rst_link", link_data, 0);
    check("rst_redir_pc", redirect_pc, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    #1;
    xact(32'h100, 5, 5, 32'h20, ALU_OP_BEQ, 0, 0, 1, 32'h120, 0, 0);
    xact(32'h108, 7, 7, 32'h10, ALU_OP_BEQ, 0, 0, 1, 32'h118, 0, 0);
    xact(32'h200, 32'hFFFF_FFFF, 1, 32'h40, ALU_OP_BLT, 0, 0, 0, 0, 0, 0);
    xact(32'h200, 32'hFFFF_FFFF, 1, 32'h40, ALU_OP_BLTU, 0, 0, 0, 0, 0, 0);
    xact(32'h300, 32'h1003, 0, 0, ALU_OP_BEQ, 0, 1, 1, 32'h1000, 0, 0);
    xact(32'hFFFF_FFFC, 1, 2, 8, ALU_OP_BNE, 0, 0, 0, 0, 0, 0);
    xact(32'h400, 3, 3, 32'h0, 3'b010, 0, 0, 1, 32'h400, 0, 0);
    xact(32'h500, 9, 4, 32'h80, ALU_OP_BGE, 0, 0, 0, 0, 1, 0);
    xact(32'h600, 0, 0, 32'h100, ALU_OP_BEQ, 1, 0, 0, 0, 0, 1);
    drive(32'h700, 1, 1, 4, ALU_OP_BEQ, 0, 0, 0, 0);
    kill = 1;
    #1;
    check("kill_blocks_ready", 32'(req_ready), 0);
    @(negedge clk);
    req_valid = 0;
    kill = 0;
    #1;
    check("kill_no_accept", 32'(resp_valid), 0);
    check("kill_idle", 32'(req_ready), 1);
    drive(32'h800, 2, 2, 32'h40, ALU_OP_BEQ, 0, 0, 0, 0);
    @(negedge clk);
    req_valid = 0;
    @(negedge clk);
    #1;
    check("pre_rst_flush", 32'(flush), 1);
    rst_n = 0;
    #1;
    check("arst_flush", 32'(flush), 0);
    check("arst_ready", 32'(req_ready), 1);
    @(negedge clk);
    rst_n = 1;
    #1;
    for (int n = 0; n < 300; n++) begin
      r = $urandom_range(0, 5);
      jal = r == 0;
      jalr = r == 1;
      op = br_op_t'($urandom_range(0, 7));
      pc = $urandom() & 32'hFFFF_FFFC;
      rs1 = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 3)) : $urandom();
      rs2 = ($urandom_range(0, 2) == 0) ? rs1 : $urandom();
      imm = $urandom() & 32'hFFFF_FFFE;
      if ($urandom_range(0, 1) == 1) imm = imm & 32'h0000_0FFC;
      pt = 1'($urandom_range(0, 1));
      ptgt = ($urandom_range(0, 1) == 1) ? tgt_of(pc, rs1, imm, jalr) : $urandom();
      xact(pc, rs1, rs2, imm, op, jal, jalr, pt, ptgt,
           $urandom_range(0, 9) == 0, $urandom_range(0, 5) == 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
endmodule

// File: doc/branch_resolve_ctrl.md
Name: branch_resolve_ctrl

Overview:
Sequences conditional-branch and jump resolution in the execute stage. Accepts one decoded control-transfer request per handshake and drives the shared branch comparator with the registered operands. Computes the actual next PC, compares it against the front-end prediction, and on mispredict issues a one-cycle redirect plus a counted multi-cycle pipeline flush. Sits between the ID/EX register and the fetch PC mux / hazard unit.

Parameters:
XLEN, 32, datapath and PC width; must equal `XLEN from constants.vh
FLUSH_CYCLES, 2, cycles flush is held after a redirect; legal range 1..15
CNT_W, 4, flush counter width; must satisfy 2**CNT_W > FLUSH_CYCLES

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  block can accept a request this cycle
req_pc  in  XLEN  PC of the branch/jump
req_rs1  in  XLEN  rs1 operand
req_rs2  in  XLEN  rs2 operand
req_imm  in  XLEN  sign-extended immediate
req_br_op  in  `BRANCH_OP_WIDTH  comparator op; used only for conditional branches
req_is_jal  in  1  JAL; unconditionally taken
req_is_jalr  in  1  JALR; unconditionally taken
req_pred_taken  in  1  front-end prediction
req_pred_target  in  XLEN  predicted target; don't-care when pred_taken=0
kill  in  1  synchronous squash from a later stage
resp_valid  out  1  one-cycle pulse: resolution complete
resp_taken  out  1  actual direction
resp_mispredict  out  1  prediction was wrong
resp_misalign  out  1  taken target has bit[1] set
link_data  out  XLEN  req_pc+4 for the JAL/JALR writeback
redirect_valid  out  1  one-cycle pulse to the fetch PC mux
redirect_pc  out  XLEN  corrected next PC
flush  out  1  squash younger IF/ID contents

Behaviour:
- Reset: state=IDLE; all outputs 0 except req_ready=1; operand registers and counter cleared.
- States: IDLE, EVAL, FLUSH.
- req_ready = (state==IDLE) & ~kill. Accept when req_valid & req_ready; all req_* fields are registered and the state moves to EVAL.
- EVAL takes 1 cycle and drives the comparator from the registered operands. cmp_out is the comparator result, 0 for an unknown op.
  - taken = jal | jalr | cmp_out.
  - Branch/JAL target = pc+imm; JALR target = (rs1+imm) & ~1. All adds are modulo 2**XLEN (wrap silently).
  - next_pc = taken ? target : pc+4.
  - mispredict = (taken != pred_taken) | (taken & pred_taken & target != pred_target).
  - misalign = taken & target[1].
  - Outputs: resp_valid=1 with resp_taken, resp_mispredict and resp_misalign. link_data=pc+4 is valid while resp_valid=1.
- Transitions from EVAL:
  - misalign: no redirect and no flush; go to IDLE. The trap is handled downstream. resp_mispredict is still reported.
  - mispredict & ~misalign: in the same cycle redirect_valid=1 and redirect_pc=next_pc; load counter=FLUSH_CYCLES; go to FLUSH.
  - otherwise: go to IDLE.
- FLUSH: flush=1 and the counter decrements each cycle. Go to IDLE on the cycle the counter reaches 1, so flush is high for exactly FLUSH_CYCLES cycles starting the cycle after redirect.
- Latency: accept at cycle N, response/redirect at N+1, next accept no earlier than N+2 (N+2+FLUSH_CYCLES on a redirect).
- kill in any state: next state IDLE, counter cleared, no request accepted that cycle.
  - kill during EVAL suppresses resp_valid and redirect_valid in that cycle (outputs gated combinationally).
  - kill during FLUSH truncates flush.
  - kill with req_valid: kill wins.
- redirect_valid, resp_valid and flush are registered or state-decoded; no output depends combinationally on req_* inputs.
- Async reset mid-EVAL or mid-FLUSH returns to the reset state immediately; the in-flight request is lost.

Decomposition:
- constants.vh (shared): XLEN, BRANCH_OP_WIDTH, ALU_OP_* comparator encodings, and a new BR_STATE_* encoding for IDLE/EVAL/FLUSH.
- Sub-module: one instance of the existing branch_comp comparator, driven by the registered rs1/rs2/br_op. No other sub-modules.

Test Plan:
- BEQ rs1=5, rs2=5, pc=0x100, imm=0x20, pred_taken=1, pred_target=0x120 -> resp_taken=1, resp_mispredict=0, no redirect, req_ready back to 1 two cycles after accept.
- BLT rs1=0xFFFFFFFF, rs2=1, pred_taken=0, pc=0x200, imm=0x40 -> taken, redirect_valid pulse with redirect_pc=0x240, flush high exactly 2 cycles; BLTU on the same operands -> not taken, no redirect.
- JALR rs1=0x1003, imm=0, pred_taken=1, pred_target=0x1000 -> target 0x1002, resp_misalign=1, no redirect/flush, link_data=pc+4.
- BNE rs1=1, rs2=2, pc=0xFFFFFFFC, imm=8, pred_taken=0 -> redirect_pc=0x00000004 (wrap).
- kill asserted in the EVAL cycle of a mispredicting branch -> no resp_valid, no redirect, state IDLE next cycle; kill together with req_valid in IDLE -> request not accepted.
- rst_n dropped during FLUSH -> flush=0 and req_ready=1 immediately (asynchronously); back-to-back correct predictions accepted every 2 cycles.
